// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: downstream request fields and FSM states.
package mem_access_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
  } mem_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitR,
    StDone
  } state_e;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of SIC-side request/grant signals and the downstream memory handshake.
interface mem_access_arbiter_if #(
  parameter int unsigned NUM_SICS = 4,
  parameter int unsigned ID_WIDTH = 6
);
  import mem_access_arbiter_pkg::*;

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
  } rpl_req_t;

  rpl_req_t [NUM_SICS-1:0] sic_rpl;
  mem_req_t [NUM_SICS-1:0] sic_req;
  logic [ID_WIDTH-1:0]     head_id;
  logic [NUM_SICS-1:0]     sic_grant;
  logic [31:0]             sic_rdata;

  logic                    mem_valid;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_we;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [31:0]             mem_rdata;

  modport master (
    input  sic_rpl, sic_req, head_id, mem_ready, mem_rvalid, mem_rdata,
    output sic_grant, sic_rdata, mem_valid, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output sic_rpl, sic_req, head_id, mem_ready, mem_rvalid, mem_rdata,
    input  sic_grant, sic_rdata, mem_valid, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_access_arbiter_age_select.sv
// Combinational oldest-first selector: minimum (id - head_id) modulo 2^ID_WIDTH, lowest index on ties.
module age_select #(
  parameter int unsigned NUM_SICS = 4,
  parameter int unsigned ID_WIDTH = 6,
  localparam int unsigned IdxW    = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1
) (
  input  logic [NUM_SICS-1:0]               valid_i,
  input  logic [NUM_SICS-1:0][ID_WIDTH-1:0] id_i,
  input  logic [ID_WIDTH-1:0]               head_id_i,
  output logic                              found_o,
  output logic [IdxW-1:0]                   idx_o
);

  logic [ID_WIDTH-1:0] age;
  logic [ID_WIDTH-1:0] best_age;

  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    age      = '0;
    best_age = '0;
    for (int i = 0; i < int'(NUM_SICS); i++) begin
      if (valid_i[i]) begin
        age = id_i[i] - head_id_i;
        // Strict compare keeps the lower index on equal age.
        if (!found_o || (age < best_age)) begin
          found_o  = 1'b1;
          best_age = age;
          idx_o    = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Age-ordered arbiter serialising SIC memory accesses onto a single downstream port.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SICS = 4,
  parameter int unsigned ID_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     win_idx_q, win_idx_d;
  logic [ID_WIDTH-1:0] win_id_q, win_id_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NUM_SICS-1:0]               elig;
  logic [NUM_SICS-1:0][ID_WIDTH-1:0] ids;
  logic                              found;
  logic [IdxW-1:0]                   sel_idx;
  logic                              win_ok;
  logic                              mem_valid_c;
  logic [NUM_SICS-1:0]               grant_c;

  always_comb begin
    elig = '0;
    ids  = '0;
    for (int i = 0; i < int'(NUM_SICS); i++) begin
      elig[i] = bus.sic_rpl[i].valid & (bus.sic_req[i].wen ^ bus.sic_req[i].ren);
      ids[i]  = bus.sic_rpl[i].id;
    end
  end

  age_select #(
    .NUM_SICS(NUM_SICS),
    .ID_WIDTH(ID_WIDTH)
  ) u_age_select (
    .valid_i  (elig),
    .id_i     (ids),
    .head_id_i(bus.head_id),
    .found_o  (found),
    .idx_o    (sel_idx)
  );

  // Winner still presenting the same instruction it was latched with.
  assign win_ok = bus.sic_rpl[win_idx_q].valid && (bus.sic_rpl[win_idx_q].id == win_id_q);

  always_comb begin
    state_d     = state_q;
    win_idx_d   = win_idx_q;
    win_id_d    = win_id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    mem_valid_c = 1'b0;
    grant_c     = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          win_idx_d = sel_idx;
          win_id_d  = ids[sel_idx];
          addr_d    = bus.sic_req[sel_idx].addr;
          wdata_d   = bus.sic_req[sel_idx].wdata;
          we_d      = bus.sic_req[sel_idx].wen;
          rdata_d   = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (!win_ok) begin
          state_d = StIdle;
        end else begin
          mem_valid_c = 1'b1;
          if (bus.mem_ready) begin
            state_d = we_q ? StDone : StWaitR;
          end
        end
      end
      StWaitR: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        if (win_ok) begin
          grant_c[win_idx_q] = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      win_idx_q <= '0;
      win_id_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      win_id_q  <= win_id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.sic_grant = grant_c;
  assign bus.sic_rdata = (state_q == StDone) ? rdata_q : 32'd0;
  assign bus.mem_valid = mem_valid_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_valid_c & we_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with an expected-grant scoreboard queue.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int unsigned NumSics = 4;
  localparam int unsigned IdW     = 6;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_arbiter_if #(.NUM_SICS(NumSics), .ID_WIDTH(IdW)) bus ();

  mem_access_arbiter #(
    .NUM_SICS(NumSics),
    .ID_WIDTH(IdW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < int'(NumSics); i++) begin
      bus.sic_rpl[i] = '0;
      bus.sic_req[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] id, input logic wen, input logic ren,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.sic_rpl[i].valid = 1'b1;
    bus.sic_rpl[i].id    = id;
    bus.sic_req[i].wen   = wen;
    bus.sic_req[i].ren   = ren;
    bus.sic_req[i].addr  = addr;
    bus.sic_req[i].wdata = wdata;
  endtask

  task automatic drop(input int i);
    bus.sic_rpl[i].valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] d);
    exp_t e;
    e.grant = g;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic grant_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(bus.sic_grant), 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(bus.sic_grant), 32'(e.grant));
    chk({tag, "_rdata"}, bus.sic_rdata, e.rdata);
  endtask

  // Returns at the negedge where a grant is seen, or checks the bare bus on timeout.
  task automatic wait_grant(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.sic_grant != '0) break;
    end
    grant_check(tag);
  endtask

  initial begin
    rst            = 1'b1;
    clear_reqs();
    bus.head_id    = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(bus.sic_grant), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_sic_rdata", bus.sic_rdata, 32'd0);

    // Single write: cycle 0 request, cycle 1 issue, cycle 2 grant.
    step();
    rst = 1'b0;
    set_req(1, 6'd5, 1'b1, 1'b0, 32'h100, 32'hAB);
    bus.mem_ready = 1'b1;
    push(4'b0010, 32'd0);
    @(negedge clk);
    chk("wr_c0_valid", 32'(bus.mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("wr_c1_valid", 32'(bus.mem_valid), 32'd1);
    chk("wr_c1_addr", bus.mem_addr, 32'h100);
    chk("wr_c1_wdata", bus.mem_wdata, 32'hAB);
    chk("wr_c1_we", 32'(bus.mem_we), 32'd1);
    chk("wr_c1_grant", 32'(bus.sic_grant), 32'd0);
    step();
    @(negedge clk);
    grant_check("wr_c2");
    step();
    clear_reqs();
    @(negedge clk);
    chk("wr_c3_grant", 32'(bus.sic_grant), 32'd0);

    // Read with backpressure then a delayed response.
    step();
    bus.mem_ready = 1'b0;
    set_req(0, 6'd7, 1'b0, 1'b1, 32'h40, 32'd0);
    push(4'b0001, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_idle_valid", 32'(bus.mem_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("rd_stall_valid", 32'(bus.mem_valid), 32'd1);
      chk("rd_stall_addr", bus.mem_addr, 32'h40);
      chk("rd_stall_we", 32'(bus.mem_we), 32'd0);
    end
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("rd_accept_valid", 32'(bus.mem_valid), 32'd1);
    step();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rd_waitr_valid", 32'(bus.mem_valid), 32'd0);
    chk("rd_waitr_grant", 32'(bus.sic_grant), 32'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rvalid_grant", 32'(bus.sic_grant), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    @(negedge clk);
    grant_check("rd_done");
    step();
    clear_reqs();
    @(negedge clk);
    chk("rd_after_grant", 32'(bus.sic_grant), 32'd0);

    // Wrap-around age: head 62, id 63 is older than id 1.
    step();
    bus.head_id   = 6'd62;
    bus.mem_ready = 1'b1;
    set_req(2, 6'd1, 1'b1, 1'b0, 32'h200, 32'h22);
    set_req(3, 6'd63, 1'b1, 1'b0, 32'h300, 32'h33);
    push(4'b1000, 32'd0);
    push(4'b0100, 32'd0);
    wait_grant("wrap_sic3", 10);
    step();
    drop(3);
    wait_grant("wrap_sic2", 10);
    step();
    drop(2);
    bus.head_id = '0;

    // Equal ids go to the lower index; ren=wen=1 is never eligible.
    step();
    set_req(0, 6'd9, 1'b1, 1'b0, 32'h10, 32'h1);
    set_req(1, 6'd2, 1'b1, 1'b1, 32'h18, 32'h7);
    set_req(2, 6'd9, 1'b1, 1'b0, 32'h20, 32'h5);
    push(4'b0001, 32'd0);
    push(4'b0100, 32'd0);
    wait_grant("tie_sic0", 10);
    step();
    drop(0);
    wait_grant("tie_sic2", 10);
    step();
    drop(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("illegal_grant", 32'(bus.sic_grant), 32'd0);
      chk("illegal_valid", 32'(bus.mem_valid), 32'd0);
    end
    step();
    clear_reqs();

    // Withdrawal in ISSUE before acceptance.
    step();
    bus.mem_ready = 1'b0;
    set_req(3, 6'd4, 1'b1, 1'b0, 32'h44, 32'h4);
    @(negedge clk);
    chk("wd_idle_valid", 32'(bus.mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("wd_issue_valid", 32'(bus.mem_valid), 32'd1);
    step();
    drop(3);
    @(negedge clk);
    chk("wd_drop_valid", 32'(bus.mem_valid), 32'd0);
    chk("wd_drop_we", 32'(bus.mem_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("wd_after_valid", 32'(bus.mem_valid), 32'd0);
      chk("wd_after_grant", 32'(bus.sic_grant), 32'd0);
    end

    // Withdrawal after read acceptance: access completes, no grant.
    step();
    bus.mem_ready = 1'b1;
    set_req(1, 6'd8, 1'b0, 1'b1, 32'h80, 32'd0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("wda_issue_valid", 32'(bus.mem_valid), 32'd1);
    step();
    bus.mem_ready = 1'b0;
    drop(1);
    @(negedge clk);
    chk("wda_waitr_valid", 32'(bus.mem_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    @(negedge clk);
    chk("wda_rvalid_grant", 32'(bus.sic_grant), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("wda_done_grant", 32'(bus.sic_grant), 32'd0);
    step();
    bus.mem_ready = 1'b1;
    set_req(2, 6'd9, 1'b1, 1'b0, 32'h90, 32'h9);
    push(4'b0100, 32'd0);
    @(negedge clk);
    chk("wda_next_idle", 32'(bus.mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("wda_next_issue", 32'(bus.mem_valid), 32'd1);
    chk("wda_next_addr", bus.mem_addr, 32'h90);
    step();
    @(negedge clk);
    grant_check("wda_next_done");
    step();
    clear_reqs();

    // Reset while waiting for read data; the late response must be ignored.
    step();
    bus.mem_ready = 1'b1;
    set_req(0, 6'd3, 1'b0, 1'b1, 32'h30, 32'd0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rstw_issue_valid", 32'(bus.mem_valid), 32'd1);
    step();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rstw_waitr_valid", 32'(bus.mem_valid), 32'd0);
    step();
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    step();
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD;
    @(negedge clk);
    chk("rstw_grant", 32'(bus.sic_grant), 32'd0);
    chk("rstw_valid", 32'(bus.mem_valid), 32'd0);
    chk("rstw_rdata", bus.sic_rdata, 32'd0);
    chk("rstw_addr", bus.mem_addr, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    @(negedge clk);
    chk("rstw_stray_grant", 32'(bus.sic_grant), 32'd0);
    chk("rstw_stray_rdata", bus.sic_rdata, 32'd0);
    step();
    bus.mem_ready = 1'b1;
    set_req(1, 6'd2, 1'b1, 1'b0, 32'h11, 32'h22);
    push(4'b0010, 32'd0);
    @(negedge clk);
    chk("rstw_new_idle", 32'(bus.mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("rstw_new_issue", 32'(bus.mem_valid), 32'd1);
    chk("rstw_new_addr", bus.mem_addr, 32'h11);
    step();
    @(negedge clk);
    grant_check("rstw_new_done");
    step();
    clear_reqs();
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
